// File: rtl/bpred_pkg.sv
// Shared types and constants for the branch-predictor table sink.
package bpred_pkg;

  localparam int unsigned ENTRIES = 256;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = 7;
  localparam int unsigned TGT_W   = 32;

  // PC slicing: word-aligned index above bit 1, tag directly above the index
  localparam int unsigned IDX_LSB = 2;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] target;
  } btb_entry_t;

  // 2-bit counter encoding
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic {
    StInit,
    StReady
  } state_e;

endpackage

// File: rtl/bpred_sat_counter.sv
// Combinational next-value for a 2-bit saturating branch counter.
module bpred_sat_counter
  import bpred_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  // Step toward the outcome, holding at the strong ends
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/bpred_table_sink.sv
// BTB/BHT storage: absorbs the in-order init sweep, then serves lookups and updates.
module bpred_table_sink
  import bpred_pkg::*;
(
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        init_valid_i,
  input  logic [39:0] btb_init_i,
  input  logic [7:0]  btb_addr_i,
  input  logic [1:0]  bht_init_i,
  input  logic [7:0]  bht_addr_i,
  input  logic        flush_i,
  output logic        init_done_o,
  output logic        init_err_o,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  output logic        pred_valid_o,
  output logic        pred_hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  // Storage arrays carry no reset; only control state does
  btb_entry_t btb_mem [ENTRIES];
  logic [1:0] bht_mem [ENTRIES];

  state_e           state_q;
  logic [IDX_W-1:0] exp_idx_q;
  logic             init_done_q;
  logic             init_err_q;
  logic             pred_valid_q;
  logic             pred_hit_q;
  logic             pred_taken_q;
  logic [TGT_W-1:0] pred_target_q;

  logic             is_ready;
  logic             beat_ok;
  logic             init_wr;
  logic             init_bad;
  logic             lk_en;
  logic             up_en;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  btb_entry_t       lk_entry;
  logic [1:0]       lk_cnt;
  logic             lk_hit;
  logic [1:0]       up_cnt_next;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc_i[IDX_LSB +: IDX_W];
  assign lk_tag = lookup_pc_i[TAG_LSB +: TAG_W];
  assign up_idx = upd_pc_i[IDX_LSB +: IDX_W];
  assign up_tag = upd_pc_i[TAG_LSB +: TAG_W];

  assign unused_pc_bits = ^{lookup_pc_i[31:TAG_LSB+TAG_W], lookup_pc_i[IDX_LSB-1:0],
                            upd_pc_i[31:TAG_LSB+TAG_W], upd_pc_i[IDX_LSB-1:0]};

  // Decode beat acceptance and the READY-only lookup/update enables
  always_comb begin
    is_ready = (state_q == StReady);
    beat_ok  = init_valid_i && (btb_addr_i == exp_idx_q) && (bht_addr_i == exp_idx_q);
    init_wr  = !is_ready && !flush_i && beat_ok;
    init_bad = !is_ready && !flush_i && init_valid_i && !beat_ok;
    // A flush cycle drops any concurrent lookup or update
    lk_en    = is_ready && !flush_i && lookup_valid_i;
    up_en    = is_ready && !flush_i && upd_valid_i;
    lk_entry = btb_mem[lk_idx];
    lk_cnt   = bht_mem[lk_idx];
    lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
  end

  bpred_sat_counter u_sat_counter (
    .cnt_i   (bht_mem[up_idx]),
    .taken_i (upd_taken_i),
    .cnt_o   (up_cnt_next)
  );

  // Control FSM plus registered status and prediction outputs
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StInit;
      exp_idx_q     <= '0;
      init_done_q   <= 1'b0;
      init_err_q    <= 1'b0;
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      init_err_q    <= init_bad;
      pred_valid_q  <= lk_en;
      pred_hit_q    <= lk_en && lk_hit;
      pred_taken_q  <= lk_en && lk_hit && lk_cnt[1];
      pred_target_q <= (lk_en && lk_hit) ? lk_entry.target : '0;
      case (state_q)
        StInit: begin
          if (flush_i) begin
            exp_idx_q <= '0;
          end else if (init_wr) begin
            if (&exp_idx_q) begin
              state_q     <= StReady;
              init_done_q <= 1'b1;
              exp_idx_q   <= '0;
            end else begin
              exp_idx_q <= exp_idx_q + 1'b1;
            end
          end else if (init_bad) begin
            // Out-of-order beat forces the sweep to restart from entry 0
            exp_idx_q <= '0;
          end
        end
        StReady: begin
          if (flush_i) begin
            state_q     <= StInit;
            init_done_q <= 1'b0;
            exp_idx_q   <= '0;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // Array writes: init sweep in INIT, resolved-branch updates in READY
  always_ff @(posedge clk) begin
    if (init_wr) begin
      btb_mem[exp_idx_q] <= btb_init_i;
      bht_mem[exp_idx_q] <= bht_init_i;
    end else if (up_en) begin
      bht_mem[up_idx] <= up_cnt_next;
      if (upd_taken_i) begin
        btb_mem[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target_i};
      end
    end
  end

  assign init_done_o   = init_done_q;
  assign init_err_o    = init_err_q;
  assign pred_valid_o  = pred_valid_q;
  assign pred_hit_o    = pred_hit_q;
  assign pred_taken_o  = pred_taken_q;
  assign pred_target_o = pred_target_q;

endmodule

// File: tb/tb_bpred_table_sink.sv
// Scoreboard bench for bpred_table_sink: model arrays predict every lookup result.
module tb_bpred_table_sink;

  logic        clk;
  logic        rst_ni;
  logic        init_valid_i;
  logic [39:0] btb_init_i;
  logic [7:0]  btb_addr_i;
  logic [1:0]  bht_init_i;
  logic [7:0]  bht_addr_i;
  logic        flush_i;
  logic        init_done_o;
  logic        init_err_o;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        pred_valid_o;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;

  bpred_table_sink dut (
    .clk            (clk),
    .rst_ni         (rst_ni),
    .init_valid_i   (init_valid_i),
    .btb_init_i     (btb_init_i),
    .btb_addr_i     (btb_addr_i),
    .bht_init_i     (bht_init_i),
    .bht_addr_i     (bht_addr_i),
    .flush_i        (flush_i),
    .init_done_o    (init_done_o),
    .init_err_o     (init_err_o),
    .lookup_valid_i (lookup_valid_i),
    .lookup_pc_i    (lookup_pc_i),
    .pred_valid_o   (pred_valid_o),
    .pred_hit_o     (pred_hit_o),
    .pred_taken_o   (pred_taken_o),
    .pred_target_o  (pred_target_o),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_target_i   (upd_target_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          hit;
    bit          taken;
    logic [31:0] target;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [39:0] m_btb [256];
  logic [1:0]  m_bht [256];
  bit          model_ready;
  int          checks;
  int          errors;
  int          cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Each response is due exactly one cycle after its request; otherwise outputs stay 0
  always @(negedge clk) begin
    if (rst_ni) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        checks++;
        if ({pred_valid_o, pred_hit_o, pred_taken_o, pred_target_o} !==
            {1'b1, mon_e.hit, mon_e.taken, mon_e.target}) begin
          errors++;
          $display("FAIL %s: got v=%b hit=%b taken=%b tgt=%h, want v=1 hit=%b taken=%b tgt=%h",
                   mon_e.name, pred_valid_o, pred_hit_o, pred_taken_o, pred_target_o,
                   mon_e.hit, mon_e.taken, mon_e.target);
        end
      end else begin
        checks++;
        if ({pred_valid_o, pred_hit_o, pred_taken_o, pred_target_o} !== 35'd0) begin
          errors++;
          $display("FAIL idle_pred @%0d: got v=%b hit=%b taken=%b tgt=%h, want all 0", cyc,
                   pred_valid_o, pred_hit_o, pred_taken_o, pred_target_o);
        end
      end
    end
  end

  function automatic exp_t predict(input logic [31:0] pc, input string nm);
    exp_t        e;
    logic [7:0]  idx;
    logic [39:0] ent;
    idx      = pc[9:2];
    ent      = m_btb[idx];
    e.hit    = ent[39] && (ent[38:32] == pc[16:10]);
    e.taken  = e.hit && m_bht[idx][1];
    e.target = e.hit ? ent[31:0] : 32'd0;
    e.name   = nm;
    e.due    = 0;
    return e;
  endfunction

  // One clock of lookup/update/flush stimulus; expectations come from the model
  task automatic cycle(input bit lv, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                       input bit fl, input string nm);
    exp_t       e;
    logic [7:0] idx;
    lookup_valid_i = lv;
    lookup_pc_i    = lpc;
    upd_valid_i    = uv;
    upd_pc_i       = upc;
    upd_taken_i    = ut;
    upd_target_i   = utgt;
    flush_i        = fl;
    if (lv && model_ready && !fl) begin
      e     = predict(lpc, nm);
      e.due = cyc + 1;
      sb.push_back(e);
    end
    if (uv && model_ready && !fl) begin
      idx = upc[9:2];
      if (ut) begin
        m_bht[idx] = (m_bht[idx] == 2'd3) ? 2'd3 : m_bht[idx] + 2'd1;
        m_btb[idx] = {1'b1, upc[16:10], utgt};
      end else begin
        m_bht[idx] = (m_bht[idx] == 2'd0) ? 2'd0 : m_bht[idx] - 2'd1;
      end
    end
    if (fl) model_ready = 1'b0;
    @(posedge clk);
    #1;
    lookup_valid_i = 1'b0;
    upd_valid_i    = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic beat(input bit v, input logic [7:0] ab, input logic [7:0] ah,
                      input logic [39:0] d, input logic [1:0] h);
    init_valid_i = v;
    btb_addr_i   = ab;
    bht_addr_i   = ah;
    btb_init_i   = d;
    bht_init_i   = h;
    @(posedge clk);
    #1;
    init_valid_i = 1'b0;
  endtask

  task automatic sweep(input bit pat, input string nm);
    int          err_seen;
    logic [7:0]  a;
    logic [39:0] d;
    logic [1:0]  h;
    err_seen = 0;
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      d = pat ? {1'b1, a[6:0], 32'h0000_0100 + {22'd0, a, 2'b00}} : 40'd0;
      h = pat ? a[1:0] : 2'b00;
      m_btb[a] = d;
      m_bht[a] = h;
      beat(1'b1, a, a, d, h);
      if (init_err_o) err_seen++;
      if (i == 254) begin
        checks++;
        if (init_done_o !== 1'b0) begin
          errors++;
          $display("FAIL %s_done_early: got %b want 0", nm, init_done_o);
        end
      end
      if (i == 255) begin
        checks++;
        if (init_done_o !== 1'b1) begin
          errors++;
          $display("FAIL %s_done: got %b want 1", nm, init_done_o);
        end
      end
    end
    checks++;
    if (err_seen != 0) begin
      errors++;
      $display("FAIL %s_err_pulses: got %0d want 0", nm, err_seen);
    end
    model_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({init_done_o, init_err_o, pred_valid_o, pred_hit_o, pred_taken_o, pred_target_o}
        !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b err=%b v=%b h=%b t=%b tgt=%h want all 0",
               init_done_o, init_err_o, pred_valid_o, pred_hit_o, pred_taken_o,
               pred_target_o);
    end
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_sweep();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      beat(1'b1, i[7:0], i[7:0], 40'd0, 2'd0);
      if (init_err_o) pulses++;
    end
    beat(1'b1, 8'd18, 8'd18, 40'd0, 2'd0);
    if (init_err_o) pulses++;
    beat(1'b0, 8'd0, 8'd0, 40'd0, 2'd0);
    if (init_err_o) pulses++;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bad_addr_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr_done: got %b want 0", init_done_o);
    end
    // BTB and BHT addresses disagree
    beat(1'b1, 8'd0, 8'd1, 40'd0, 2'd0);
    checks++;
    if (init_err_o !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_err: got %b want 1", init_err_o);
    end
    beat(1'b0, 8'd0, 8'd0, 40'd0, 2'd0);
    sweep(1'b0, "zero_sweep");
  endtask

  task automatic test_update_lookup();
    cycle(0, 0, 1, 32'h0000_0404, 1, 32'h0000_1000, 0, "upd1");
    cycle(1, 32'h0000_0404, 0, 0, 0, 0, 0, "lk_after_1_taken");
    cycle(0, 0, 1, 32'h0000_0404, 1, 32'h0000_1000, 0, "upd2");
    cycle(1, 32'h0000_0404, 0, 0, 0, 0, 0, "lk_after_2_taken");
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h0000_0404, 0, 32'h0, 0, "upd_nt");
    cycle(1, 32'h0000_0404, 0, 0, 0, 0, 0, "lk_after_4_nt");
    cycle(1, 32'h0000_8404, 0, 0, 0, 0, 0, "lk_tag_miss");
    cycle(1, 32'h0000_0800, 0, 0, 0, 0, 0, "lk_invalid_entry");
  endtask

  task automatic test_same_cycle();
    cycle(1, 32'h0000_0404, 1, 32'h0000_0404, 1, 32'h0000_2000, 0, "lk_same_cycle_old");
    cycle(1, 32'h0000_0404, 0, 0, 0, 0, 0, "lk_after_same_cycle");
    cycle(1, 32'h0000_0404, 1, 32'h0000_0404, 0, 32'h0, 0, "lk_b2b_1");
    cycle(1, 32'h0000_0404, 0, 0, 0, 0, 0, "lk_b2b_2");
  endtask

  task automatic test_ready_ignores_init();
    beat(1'b1, 8'd1, 8'd1, {1'b1, 7'd1, 32'hdead_beef}, 2'd3);
    checks++;
    if (init_err_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_init_err: got %b want 0", init_err_o);
    end
    cycle(1, 32'h0000_0404, 0, 0, 0, 0, 0, "lk_after_ready_beat");
  endtask

  task automatic test_async_reset();
    lookup_valid_i = 1'b1;
    lookup_pc_i    = 32'h0000_0404;
    @(posedge clk);
    #1;
    lookup_valid_i = 1'b0;
    checks++;
    if ({pred_valid_o, init_done_o} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_state: got v=%b done=%b want 1 1", pred_valid_o, init_done_o);
    end
    rst_ni = 1'b0;
    model_ready = 1'b0;
    #1;
    checks++;
    if ({init_done_o, pred_valid_o, pred_hit_o, pred_target_o} !== 35'd0) begin
      errors++;
      $display("FAIL async_reset: got done=%b v=%b h=%b tgt=%h want all 0",
               init_done_o, pred_valid_o, pred_hit_o, pred_target_o);
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 100; i++) beat(1'b1, i[7:0], i[7:0], 40'd0, 2'd0);
    init_valid_i = 1'b1;
    btb_addr_i   = 8'd100;
    bht_addr_i   = 8'd100;
    #2;
    rst_ni = 1'b0;
    #1;
    init_valid_i = 1'b0;
    checks++;
    if ({init_done_o, init_err_o, pred_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL mid_sweep_reset: got done=%b err=%b v=%b want 0 0 0",
               init_done_o, init_err_o, pred_valid_o);
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    // Resuming at 100 must now be rejected
    beat(1'b1, 8'd100, 8'd100, 40'd0, 2'd0);
    checks++;
    if (init_err_o !== 1'b1) begin
      errors++;
      $display("FAIL resume_after_reset_err: got %b want 1", init_err_o);
    end
    beat(1'b0, 8'd0, 8'd0, 40'd0, 2'd0);
    sweep(1'b1, "pattern_sweep");
  endtask

  task automatic test_pattern_lookup();
    logic [7:0]  a;
    logic [31:0] pc;
    int          idxs [4] = '{0, 3, 130, 255};
    foreach (idxs[k]) begin
      a  = idxs[k][7:0];
      pc = {15'd0, a[6:0], a, 2'b00};
      cycle(1, pc, 0, 0, 0, 0, 0, "lk_pattern");
    end
    a  = 8'd77;
    pc = {15'd0, a[6:0] ^ 7'h01, a, 2'b00};
    cycle(1, pc, 0, 0, 0, 0, 0, "lk_pattern_tag_miss");
    a  = 8'd6;
    pc = {15'd0, a[6:0], a, 2'b00};
    cycle(0, 0, 1, pc, 1, 32'h0000_abc0, 0, "upd_pattern");
    cycle(1, pc, 0, 0, 0, 0, 0, "lk_pattern_after_upd");
  endtask

  task automatic test_flush();
    cycle(1, 32'h0000_0404, 1, 32'h0000_0404, 1, 32'h0000_3000, 1, "flush_ready");
    checks++;
    if (init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_done: got %b want 0", init_done_o);
    end
    cycle(1, 32'h0000_0404, 0, 0, 0, 0, 0, "lk_in_init_1");
    cycle(1, 32'h0000_0018, 0, 0, 0, 0, 0, "lk_in_init_2");
    for (int i = 0; i < 10; i++) beat(1'b1, i[7:0], i[7:0], 40'd0, 2'd0);
    cycle(0, 0, 0, 0, 0, 0, 1, "flush_init");
    beat(1'b1, 8'd10, 8'd10, 40'd0, 2'd0);
    checks++;
    if (init_err_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_init_restart: got err=%b want 1", init_err_o);
    end
    beat(1'b0, 8'd0, 8'd0, 40'd0, 2'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_ready = 1'b0;
    rst_ni = 1'b0;
    init_valid_i = 1'b0;
    btb_init_i = '0;
    btb_addr_i = '0;
    bht_init_i = '0;
    bht_addr_i = '0;
    flush_i = 1'b0;
    lookup_valid_i = 1'b0;
    lookup_pc_i = '0;
    upd_valid_i = 1'b0;
    upd_pc_i = '0;
    upd_taken_i = 1'b0;
    upd_target_i = '0;
    test_reset();
    test_bad_sweep();
    test_update_lookup();
    test_same_cycle();
    test_ready_ignores_init();
    test_async_reset();
    test_pattern_lookup();
    test_flush();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
